// File: rtl/uop_issue_queue.sv
// Microcode uop fetch and bundle issue queue with credit-based ROM reads.
// Define UOP_ISSUE_BYPASS_EN to let a return go straight to the consumer.
module uop_issue_queue #(
    parameter int UCR_ADDR_WIDTH = 8,
    parameter int ISSUE_WIDTH    = 4,
    parameter int UOP_WIDTH      = 32,
    parameter int DEPTH          = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [UCR_ADDR_WIDTH-1:0]        uop_pc,
    output logic                             uop_pc_ready,
    output logic                             macro_fetch,
    input  logic                             macroop_valid,
    output logic                             macroop_ack,
    output logic [UCR_ADDR_WIDTH-1:0]        rom_addr,
    output logic                             rom_en,
    input  logic [ISSUE_WIDTH*UOP_WIDTH-1:0] rom_data,
    input  logic                             flush,
    output logic                             bundle_valid,
    input  logic                             bundle_ready,
    output logic [ISSUE_WIDTH*UOP_WIDTH-1:0] bundle_data,
    output logic [ISSUE_WIDTH-1:0]           bundle_mask
);
    localparam int BW = ISSUE_WIDTH * UOP_WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {WAIT_MACRO, STREAM} state_t;

    state_t            state_q, state_d;
    logic              inflight_q;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [BW-1:0]     data_q [DEPTH];
    logic [ISSUE_WIDTH-1:0] mask_q [DEPTH];

    logic [ISSUE_WIDTH-1:0] last_c, mask_c;
    logic [BW-1:0]     data_c;
    logic              ret_last, byp, push, pop, not_empty;

    // Keep lanes up to and including the first last-flagged uop.
    always_comb begin
        last_c = '0;
        mask_c = '0;
        data_c = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            last_c[i] = rom_data[i*UOP_WIDTH + UOP_WIDTH - 1];
        end
        mask_c[0] = 1'b1;
        for (int i = 1; i < ISSUE_WIDTH; i++) begin
            mask_c[i] = mask_c[i-1] & ~last_c[i-1];
        end
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            data_c[i*UOP_WIDTH +: UOP_WIDTH] =
                mask_c[i] ? rom_data[i*UOP_WIDTH +: UOP_WIDTH] : '0;
        end
    end

    assign ret_last  = inflight_q & (|last_c);
    assign not_empty = (count_q != '0);

    assign macro_fetch = ~rst & ~flush &
        ((state_q == WAIT_MACRO) | ret_last);
    assign uop_pc_ready = ~rst & ~flush &
        ((count_q + CW'(inflight_q)) < DEPTH_C) &
        (~macro_fetch | macroop_valid);
    assign macroop_ack = macro_fetch & uop_pc_ready;
    assign rom_en      = uop_pc_ready;
    assign rom_addr    = uop_pc;

`ifdef UOP_ISSUE_BYPASS_EN
    assign byp = inflight_q & ~flush & ~not_empty;
`else
    assign byp = 1'b0;
`endif

    assign bundle_valid = not_empty | byp;
    assign bundle_data  = not_empty ? data_q[rptr_q] : data_c;
    assign bundle_mask  = not_empty ? mask_q[rptr_q] : mask_c;

    assign push = inflight_q & ~flush & ~(byp & bundle_ready);
    assign pop  = not_empty & bundle_ready & ~flush;

    always_comb begin
        state_d = state_q;
        count_d = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            state_d = WAIT_MACRO;
            count_d = '0;
        end else if (macroop_ack) begin
            state_d = STREAM;
        end else if (ret_last) begin
            state_d = WAIT_MACRO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_MACRO;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= uop_pc_ready;
            count_q    <= count_d;
            if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + PW'(1);
                if (pop)  rptr_q <= rptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wptr_q] <= data_c;
            mask_q[wptr_q] <= mask_c;
        end
    end
endmodule

// File: tb/tb_uop_issue_queue.sv
// Directed bench for uop_issue_queue with a behavioural ROM and fetch PC.
module tb_uop_issue_queue;
    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   uop_pc;
    logic         uop_pc_ready, macro_fetch, macroop_valid, macroop_ack;
    logic [7:0]   rom_addr;
    logic         rom_en;
    logic [127:0] rom_data;
    logic         flush;
    logic         bundle_valid, bundle_ready;
    logic [127:0] bundle_data;
    logic [3:0]   bundle_mask;

    logic [7:0]   macro_off;
    logic [7:0]   pc_q;
    int           total = 0;
    int           bad = 0;

    uop_issue_queue dut (
        .clk(clk), .rst(rst), .uop_pc(uop_pc), .uop_pc_ready(uop_pc_ready),
        .macro_fetch(macro_fetch), .macroop_valid(macroop_valid),
        .macroop_ack(macroop_ack), .rom_addr(rom_addr), .rom_en(rom_en),
        .rom_data(rom_data), .flush(flush), .bundle_valid(bundle_valid),
        .bundle_ready(bundle_ready), .bundle_data(bundle_data),
        .bundle_mask(bundle_mask)
    );

    always #5 clk = ~clk;

    // 0x10: last flag on lane 2; 0x20-0x3F: no last flags; others: lane 0.
    function automatic logic [127:0] rom_fn(input logic [7:0] a);
        logic [127:0] d;
        int lastl;
        d = '0;
        if (a == 8'h10) lastl = 2;
        else if (a >= 8'h20 && a <= 8'h3F) lastl = -1;
        else lastl = 0;
        for (int i = 0; i < 4; i++) begin
            d[i*32 +: 32] = {(i == lastl), 7'h0, a, 8'h0, 8'(i)};
        end
        return d;
    endfunction

    always @(posedge clk) begin
        rom_data <= rom_en ? rom_fn(rom_addr) : '0;
        if (rom_en) pc_q <= rom_addr + 8'h1;
    end

    assign uop_pc = macro_fetch ? macro_off : pc_q;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; macroop_valid = 1'b1; macro_off = 8'h10;
        bundle_ready = 1'b1; flush = 1'b0; pc_q = 8'h0; rom_data = '0;
        #12;
        chk("rst_bvalid", 128'(bundle_valid), 128'd0);
        chk("rst_ready", 128'(uop_pc_ready), 128'd0);
        chk("rst_mfetch", 128'(macro_fetch), 128'd0);
        chk("rst_ack", 128'(macroop_ack), 128'd0);
        chk("rst_romen", 128'(rom_en), 128'd0);
        rst = 1'b0;
        #1;
        chk("c0_mfetch", 128'(macro_fetch), 128'd1);
        chk("c0_romen", 128'(rom_en), 128'd1);
        chk("c0_ack", 128'(macroop_ack), 128'd1);
        chk("c0_addr", 128'(rom_addr), 128'h10);
        step();
        macroop_valid = 1'b0;
        #1;
        chk("c1_mfetch_last", 128'(macro_fetch), 128'd1);
        chk("c1_ready", 128'(uop_pc_ready), 128'd0);
`ifdef UOP_ISSUE_BYPASS_EN
        chk("c1_bvalid", 128'(bundle_valid), 128'd1);
        chk("c1_mask", 128'(bundle_mask), 128'h7);
        step();
        chk("c2_bvalid", 128'(bundle_valid), 128'd0);
`else
        chk("c1_bvalid", 128'(bundle_valid), 128'd0);
        step();
        chk("c2_bvalid", 128'(bundle_valid), 128'd1);
        chk("c2_mask", 128'(bundle_mask), 128'h7);
        chk("c2_data", bundle_data,
            {32'h0, 32'h80100002, 32'h00100001, 32'h00100000});
        step();
        chk("c3_bvalid", 128'(bundle_valid), 128'd0);
`endif
        chk("wait_mfetch", 128'(macro_fetch), 128'd1);
        for (int i = 0; i < 5; i++) begin
            chk("idle_ready", 128'(uop_pc_ready), 128'd0);
            chk("idle_romen", 128'(rom_en), 128'd0);
            step();
        end
        bundle_ready = 1'b0; macro_off = 8'h20; macroop_valid = 1'b1;
        #1;
        chk("idle_issue", 128'(rom_en), 128'd1);
        chk("idle_ack", 128'(macroop_ack), 128'd1);
        step();
        macroop_valid = 1'b0;
        #1;
        chk("s1_addr", 128'(rom_addr), 128'h21);
        for (int i = 0; i < 6; i++) step();
        chk("full_ready", 128'(uop_pc_ready), 128'd0);
        chk("full_bvalid", 128'(bundle_valid), 128'd1);
        chk("full_head", 128'(bundle_data[31:0]), 128'h00200000);
        chk("full_mask", 128'(bundle_mask), 128'hF);
        bundle_ready = 1'b1;
        #1;
        chk("pop_ready", 128'(uop_pc_ready), 128'd0);
        step();
        bundle_ready = 1'b0;
        #1;
        chk("after_pop_ready", 128'(uop_pc_ready), 128'd1);
        chk("after_pop_head", 128'(bundle_data[31:0]), 128'h00210000);
        chk("after_pop_addr", 128'(rom_addr), 128'h24);
        flush = 1'b1;
        #1;
        chk("flush_ready", 128'(uop_pc_ready), 128'd0);
        step();
        flush = 1'b0;
        #1;
        chk("flushed_bvalid", 128'(bundle_valid), 128'd0);
        chk("flushed_mfetch", 128'(macro_fetch), 128'd1);
        macroop_valid = 1'b1; macro_off = 8'h20;
        #1;
        chk("f2_ack", 128'(macroop_ack), 128'd1);
        step();
        macroop_valid = 1'b0;
        step();
        step();
        chk("f2_two_queued", 128'(bundle_valid), 128'd1);
        chk("f2_ret_stream", 128'(macro_fetch), 128'd0);
        flush = 1'b1;
        #1;
        chk("f2_flush_mfetch", 128'(macro_fetch), 128'd0);
        step();
        flush = 1'b0;
        #1;
        chk("f2_bvalid", 128'(bundle_valid), 128'd0);
        chk("f2_mfetch", 128'(macro_fetch), 128'd1);
        chk("f2_romen", 128'(rom_en), 128'd0);
        step();
        chk("f2_nodrop", 128'(bundle_valid), 128'd0);
        bundle_ready = 1'b1; macroop_valid = 1'b1; macro_off = 8'h10;
        #1;
        chk("r_issue", 128'(rom_en), 128'd1);
        step();
        rst = 1'b1;
        macroop_valid = 1'b0;
        #1;
        chk("r_bvalid_in_rst", 128'(bundle_valid), 128'd0);
        chk("r_mfetch_in_rst", 128'(macro_fetch), 128'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("r_no_bundle", 128'(bundle_valid), 128'd0);
            step();
        end
        macroop_valid = 1'b1;
        #1;
        chk("r_first_mfetch", 128'(macro_fetch), 128'd1);
        chk("r_first_romen", 128'(rom_en), 128'd1);
        step();
        macroop_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
